aximm_window_ctrl: RTL and testbench
====================================

// Module: aximm_window_ctrl
// PURPOSE
//  AXI4-Lite-configured controller for the BAR1 sliding-window remapper.
//  - Software stages a new 64-bit window address, then commits it.
//  - On commit: hold upstream AW/AR, drain outstanding window bursts, then
//    switch window_addr atomically. No burst ever straddles two windows.
// PARAMETERS
//  AW             64                  width of window_addr
//  CW             8                   width of outstanding-burst counters
//  DEFAULT_WINDOW 64'h0               window_addr value at reset
//  DRAIN_TIMEOUT  65535               max DRAIN cycles before commit aborts
// PORTS
//  clk            in   1      clock; all logic on rising edge
//  reset          in   1      synchronous, active-high
//  window_addr    out  AW     active window base, to remapper
//  hold           out  1      1 = upstream must deassert AWVALID/ARVALID
//  mon_aw_hs      in   1      AWVALID&AWREADY on remapper AXI4 port
//  mon_b_hs       in   1      BVALID&BREADY on remapper AXI4 port
//  mon_ar_hs      in   1      ARVALID&ARREADY on remapper AXI4 port
//  mon_rlast_hs   in   1      RVALID&RREADY&RLAST on remapper AXI4 port
//  S_AXI_*        -    -      AXI4-Lite slave, 32-bit data, 8-bit addr
//                             (AW/W/B/AR/R, AWADDR/ARADDR[7:0], WSTRB ignored)
// BEHAVIOUR
//  Reset: window_addr=DEFAULT_WINDOW, hold=0, staged=DEFAULT_WINDOW, counters=0,
//   sticky bits=0, FSM=IDLE, all S_AXI VALIDs 0, AWREADY/WREADY/ARREADY 1.
//  Register map (byte addr):
//   0x00 STAGE_LO RW  staged[31:0]     0x04 STAGE_HI RW  staged[63:32]
//   0x08 CTRL     W: b0=1 commit, b1=1 clear ERR, b2=1 clear TMO
//                 R: b0 busy(FSM!=IDLE), b1 ERR, b2 TMO
//   0x0C ACT_LO   RO window_addr[31:0]  0x10 ACT_HI RO window_addr[63:32]
//   0x14 OUTST    RO {wr_out[CW-1:0] in [23:16] region, rd_out in [7:0]}
//                    (wr_out at bits [16+:CW], rd_out at bits [0+:CW])
//  AXI-Lite write: AW and W captured independently (READY drops after capture);
//   write executes cycle both held; BVALID next cycle, held until BREADY,
//   then AWREADY/WREADY reassert. BRESP=OKAY mapped, SLVERR(2'b10) unmapped.
//  AXI-Lite read: ARREADY=1 when R idle; RVALID cycle after AR hs, held until
//   RREADY. RRESP=OKAY mapped, SLVERR + RDATA=0 unmapped. Writes to RO = SLVERR.
//  Counters: wr_out += mon_aw_hs - mon_b_hs; rd_out += mon_ar_hs - mon_rlast_hs.
//   Inc+dec same cycle: no change. Dec at 0: stays 0, set ERR. Inc at max:
//   stays max, set ERR. Counters always run, independent of FSM.
//  FSM:
//   IDLE : commit write -> HOLD (window_addr=staged value at commit cycle).
//   HOLD : hold=1 (registered, first asserted cycle after commit write) -> DRAIN.
//   DRAIN: hold=1; tmr increments; wr_out==0 && rd_out==0 -> APPLY;
//          tmr==DRAIN_TIMEOUT -> set TMO, IDLE, window_addr unchanged.
//   APPLY: window_addr<=latched staged; -> IDLE; hold=0 from next cycle.
//  Commit latency, no traffic: commit write at cycle N -> window_addr new at N+3.
//  Commit while busy: ignored, BRESP OKAY. STAGE writes while busy: allowed,
//   do not affect in-progress commit (value latched at commit).
//  Handshakes during hold=1 are still counted (upstream bug tolerance).
//  Reset mid-DRAIN: immediate return to reset state, hold=0 next edge.
//  Commit + clear bits in same CTRL write: all act.
// TESTING
//  1 Reset; read 0x0C/0x10 -> DEFAULT_WINDOW; CTRL read -> 0; hold=0.
//  2 Write STAGE_LO=0x1000_0000, STAGE_HI=0x1, CTRL=1, no traffic -> hold 1 for
//    2 cycles, ACT_HI:LO=0x1_1000_0000, busy=0 after.
//  3 Three mon_aw_hs, then commit -> stays DRAIN until 3 mon_b_hs; window
//    switches 2 cycles after last b_hs; simultaneous aw_hs+b_hs leaves count.
//  4 DRAIN_TIMEOUT=16, one mon_ar_hs never completed, commit -> TMO=1 after 16
//    DRAIN cycles, window unchanged, hold=0; CTRL write 4 clears TMO.
//  5 mon_b_hs with wr_out=0 -> ERR=1, wr_out=0; read 0x20 -> SLVERR, RDATA=0.
//  6 Assert reset mid-DRAIN -> hold=0, window=DEFAULT_WINDOW, counters 0.

Source files
------------

// File: rtl/aximm_window_ctrl_if.sv
// AXI4-Lite register-port bundle for the BAR1 window controller (32-bit data, 8-bit address).
// VALID/READY: a transfer happens on a rising edge where both are 1; VALID never waits on READY.
interface aximm_window_ctrl_if;
    logic        awvalid;
    logic        awready;
    logic [7:0]  awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [7:0]  araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/aximm_window_ctrl.sv
// BAR1 sliding-window controller: software stages a 64-bit base and commits it; the
// switch waits until every tracked window burst has drained so no burst spans two windows.
module aximm_window_ctrl #(
    parameter int              AW             = 64,
    parameter int              CW             = 8,
    parameter logic [AW-1:0]   DEFAULT_WINDOW = '0,
    parameter int              DRAIN_TIMEOUT  = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    aximm_window_ctrl_if.slave   s_axi,
    output logic [AW-1:0]        window_addr,
    output logic                 hold,
    input  logic                 mon_aw_hs,
    input  logic                 mon_b_hs,
    input  logic                 mon_ar_hs,
    input  logic                 mon_rlast_hs,
    output logic [1:0]           dbg_state
);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, HOLD, DRAIN, APPLY} state_t;

    state_t         state;
    logic [AW-1:0]  staged, latched, act;
    logic [CW-1:0]  wr_out, rd_out;
    logic [TW-1:0]  tmr;
    logic           err, tmo;

    logic           aw_full, w_full;
    logic [7:0]     wa;
    logic [31:0]    wd;
    logic           bvalid_q, arready_q, rvalid_q;
    logic [1:0]     bresp_q, rresp_q;
    logic [31:0]    rdata_q;

    logic           wr_exec, wr_mapped, ctrl_wr, commit, clr_err, clr_tmo;
    logic           wr_err, rd_err;
    logic [31:0]    rd_data_c;
    logic           rd_ok_c;

    assign s_axi.awready = ~aw_full;
    assign s_axi.wready  = ~w_full;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign window_addr = act;
    assign dbg_state   = state;

    // A write executes once both address and data are captured and no response is pending.
    assign wr_exec   = aw_full & w_full & ~bvalid_q;
    assign wr_mapped = (wa == 8'h00) || (wa == 8'h04) || (wa == 8'h08);
    assign ctrl_wr   = wr_exec & (wa == 8'h08);
    assign commit    = ctrl_wr & wd[0] & (state == IDLE);
    assign clr_err   = ctrl_wr & wd[1];
    assign clr_tmo   = ctrl_wr & wd[2];

    always_comb begin
        wr_err = 1'b0;
        rd_err = 1'b0;
        if (mon_aw_hs && !mon_b_hs && (wr_out == '1)) wr_err = 1'b1;
        if (!mon_aw_hs && mon_b_hs && (wr_out == '0)) wr_err = 1'b1;
        if (mon_ar_hs && !mon_rlast_hs && (rd_out == '1)) rd_err = 1'b1;
        if (!mon_ar_hs && mon_rlast_hs && (rd_out == '0)) rd_err = 1'b1;
    end

    always_comb begin
        rd_data_c = '0;
        rd_ok_c   = 1'b1;
        case (s_axi.araddr)
            8'h00: rd_data_c = staged[31:0];
            8'h04: rd_data_c = staged[63:32];
            8'h08: rd_data_c = {29'b0, tmo, err, state != IDLE};
            8'h0C: rd_data_c = act[31:0];
            8'h10: rd_data_c = act[63:32];
            8'h14: begin
                rd_data_c[16 +: CW] = wr_out;
                rd_data_c[0 +: CW]  = rd_out;
            end
            default: rd_ok_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            wa        <= '0;
            wd        <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            staged    <= DEFAULT_WINDOW;
        end else begin
            if (s_axi.awvalid && !aw_full) begin
                aw_full <= 1'b1;
                wa      <= s_axi.awaddr;
            end
            if (s_axi.wvalid && !w_full) begin
                w_full <= 1'b1;
                wd     <= s_axi.wdata;
            end
            if (wr_exec) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
                if (wa == 8'h00) staged[31:0]  <= wd;
                if (wa == 8'h04) staged[63:32] <= wd;
            end
            if (bvalid_q && s_axi.bready) begin
                bvalid_q <= 1'b0;
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
            end
            if (s_axi.arvalid && arready_q) begin
                arready_q <= 1'b0;
                rvalid_q  <= 1'b1;
                rdata_q   <= rd_data_c;
                rresp_q   <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
            end
            if (rvalid_q && s_axi.rready) begin
                rvalid_q  <= 1'b0;
                arready_q <= 1'b1;
            end
        end
    end

    // Outstanding-burst counters saturate at both ends and flag the violation in ERR.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_out <= '0;
            rd_out <= '0;
            err    <= 1'b0;
        end else begin
            if (mon_aw_hs && !mon_b_hs && !wr_err) wr_out <= wr_out + 1'b1;
            if (!mon_aw_hs && mon_b_hs && !wr_err) wr_out <= wr_out - 1'b1;
            if (mon_ar_hs && !mon_rlast_hs && !rd_err) rd_out <= rd_out + 1'b1;
            if (!mon_ar_hs && mon_rlast_hs && !rd_err) rd_out <= rd_out - 1'b1;
            if (wr_err || rd_err) err <= 1'b1;
            else if (clr_err)     err <= 1'b0;
        end
    end

    // The new base is driven while leaving DRAIN, so it and the hold release land together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            hold    <= 1'b0;
            act     <= DEFAULT_WINDOW;
            latched <= DEFAULT_WINDOW;
            tmr     <= '0;
            tmo     <= 1'b0;
        end else begin
            if (clr_tmo) tmo <= 1'b0;
            case (state)
                IDLE: begin
                    if (commit) begin
                        latched <= staged;
                        hold    <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    tmr   <= '0;
                    state <= DRAIN;
                end
                DRAIN: begin
                    if ((wr_out == '0) && (rd_out == '0)) begin
                        act   <= latched;
                        hold  <= 1'b0;
                        state <= APPLY;
                    end else if (tmr == TW'(DRAIN_TIMEOUT - 1)) begin
                        tmo   <= 1'b1;
                        hold  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                APPLY: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aximm_window_ctrl.sv
// Directed bench for aximm_window_ctrl: register-map vector table plus hand-written
// commit, drain, timeout, error and reset sequences.
module tb_aximm_window_ctrl;
    localparam logic [63:0] DEF = 64'hABCD_0000_0000_1000;
    localparam logic [1:0]  OKAY = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic        clk;
    logic        reset;
    logic [63:0] window_addr;
    logic        hold;
    logic        mon_aw_hs, mon_b_hs, mon_ar_hs, mon_rlast_hs;
    logic [1:0]  dbg_state;

    aximm_window_ctrl_if bus ();

    aximm_window_ctrl #(
        .AW(64), .CW(8), .DEFAULT_WINDOW(DEF), .DRAIN_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .s_axi(bus), .window_addr(window_addr), .hold(hold),
        .mon_aw_hs(mon_aw_hs), .mon_b_hs(mon_b_hs), .mon_ar_hs(mon_ar_hs),
        .mon_rlast_hs(mon_rlast_hs), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int hold_cnt = 0;

    always @(negedge clk) if (hold === 1'b1) hold_cnt++;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             output logic [1:0] resp, output logic hold_at_b);
        bit aw_done, w_done, hit_aw, hit_w, b_done;
        aw_done = 0; w_done = 0; b_done = 0;
        resp = 2'b11; hold_at_b = 1'bx;
        bus.awaddr = addr; bus.wdata = data;
        bus.awvalid = 1; bus.wvalid = 1; bus.bready = 1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            hit_aw = bus.awvalid && bus.awready;
            hit_w  = bus.wvalid && bus.wready;
            @(negedge clk);
            if (hit_aw) begin bus.awvalid = 0; aw_done = 1; end
            if (hit_w)  begin bus.wvalid = 0; w_done = 1; end
        end
        bus.awvalid = 0; bus.wvalid = 0;
        for (int i = 0; i < 20 && !b_done; i++) begin
            if (bus.bvalid) begin
                resp = bus.bresp; hold_at_b = hold; b_done = 1;
            end
            @(negedge clk);
        end
        bus.bready = 0;
        check("wr_handshake_done", {62'b0, aw_done && w_done, b_done}, 64'd3);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit ar_done, r_done, hit;
        ar_done = 0; r_done = 0;
        data = '0; resp = 2'b11;
        bus.araddr = addr; bus.arvalid = 1; bus.rready = 1;
        for (int i = 0; i < 20 && !ar_done; i++) begin
            hit = bus.arready;
            @(negedge clk);
            if (hit) begin bus.arvalid = 0; ar_done = 1; end
        end
        bus.arvalid = 0;
        for (int i = 0; i < 20 && !r_done; i++) begin
            if (bus.rvalid) begin
                data = bus.rdata; resp = bus.rresp; r_done = 1;
            end
            @(negedge clk);
        end
        bus.rready = 0;
        check("rd_handshake_done", {62'b0, ar_done, r_done}, 64'd3);
    endtask

    task automatic pulse(input logic aw, input logic b, input logic ar, input logic rl);
        mon_aw_hs = aw; mon_b_hs = b; mon_ar_hs = ar; mon_rlast_hs = rl;
        @(negedge clk);
        mon_aw_hs = 0; mon_b_hs = 0; mon_ar_hs = 0; mon_rlast_hs = 0;
    endtask

    task automatic read_expect(input string name, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d; logic [1:0] r;
        axi_read(addr, d, r);
        check({name, "_resp"}, r, OKAY);
        check(name, d, exp);
    endtask

    logic [31:0] rd;
    logic [1:0]  rr;
    logic        hb;
    int          base;
    bit          released;

    initial begin
        clk = 0; reset = 1;
        bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
        mon_aw_hs = 0; mon_b_hs = 0; mon_ar_hs = 0; mon_rlast_hs = 0;

        vecs[0]  = '{0, 8'h0C, 32'h0,         OKAY,   32'h0000_1000};
        vecs[1]  = '{0, 8'h10, 32'h0,         OKAY,   32'hABCD_0000};
        vecs[2]  = '{0, 8'h08, 32'h0,         OKAY,   32'h0};
        vecs[3]  = '{0, 8'h14, 32'h0,         OKAY,   32'h0};
        vecs[4]  = '{0, 8'h00, 32'h0,         OKAY,   32'h0000_1000};
        vecs[5]  = '{1, 8'h00, 32'h1000_0000, OKAY,   32'h0};
        vecs[6]  = '{1, 8'h04, 32'h0000_0001, OKAY,   32'h0};
        vecs[7]  = '{0, 8'h00, 32'h0,         OKAY,   32'h1000_0000};
        vecs[8]  = '{0, 8'h04, 32'h0,         OKAY,   32'h0000_0001};
        vecs[9]  = '{0, 8'h18, 32'h0,         SLVERR, 32'h0};
        vecs[10] = '{1, 8'h10, 32'h1234_5678, SLVERR, 32'h0};
        vecs[11] = '{1, 8'h24, 32'h1,         SLVERR, 32'h0};

        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("rst_hold", hold, 0);
        check("rst_window", window_addr, DEF);
        check("rst_state", dbg_state, 0);
        check("rst_ready", {61'b0, bus.awready, bus.wready, bus.arready}, 64'd7);
        check("rst_valid", {62'b0, bus.bvalid, bus.rvalid}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, rr, hb);
                check($sformatf("vec%0d_bresp", i), rr, vecs[i].resp);
            end else begin
                axi_read(vecs[i].addr, rd, rr);
                check($sformatf("vec%0d_rresp", i), rr, vecs[i].resp);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            end
        end
        check("unmapped_wr_no_effect", window_addr, DEF);

        // Commit with no traffic: hold for exactly two cycles, new base three cycles after execute.
        base = hold_cnt;
        axi_write(8'h08, 32'h1, rr, hb);
        check("c2_bresp", rr, OKAY);
        check("c2_hold_at_b", hb, 1);
        check("c2_hold_n2", hold, 1);
        check("c2_window_n2", window_addr, DEF);
        @(negedge clk);
        check("c2_window_n3", window_addr, 64'h1_1000_0000);
        check("c2_hold_n3", hold, 0);
        check("c2_hold_cycles", hold_cnt - base, 2);
        @(negedge clk);
        read_expect("c2_act_lo", 8'h0C, 32'h1000_0000);
        read_expect("c2_act_hi", 8'h10, 32'h0000_0001);
        read_expect("c2_ctrl", 8'h08, 32'h0);

        // Drain waits for three write bursts; staging during drain does not disturb the commit.
        axi_write(8'h00, 32'h2000_0000, rr, hb);
        axi_write(8'h04, 32'h0000_0002, rr, hb);
        pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(1, 0, 0, 0);
        axi_write(8'h08, 32'h1, rr, hb);
        pulse(1, 1, 0, 0);
        read_expect("c3_outst", 8'h14, 32'h0003_0000);
        axi_write(8'h00, 32'hDEAD_BEEF, rr, hb);
        check("c3_stage_busy_bresp", rr, OKAY);
        pulse(0, 1, 0, 0); pulse(0, 1, 0, 0);
        check("c3_hold_draining", hold, 1);
        check("c3_state_drain", dbg_state, 2);
        pulse(0, 1, 0, 0);
        check("c3_window_m1", window_addr, 64'h1_1000_0000);
        check("c3_hold_m1", hold, 1);
        @(negedge clk);
        check("c3_window_m2", window_addr, 64'h2_2000_0000);
        check("c3_hold_m2", hold, 0);
        @(negedge clk);
        read_expect("c3_stage_lo", 8'h00, 32'hDEAD_BEEF);

        // Read burst never completes: drain times out after 16 cycles, window kept.
        axi_write(8'h00, 32'h3000_0000, rr, hb);
        pulse(0, 0, 1, 0);
        read_expect("c4_outst", 8'h14, 32'h0000_0001);
        base = hold_cnt;
        axi_write(8'h08, 32'h1, rr, hb);
        axi_write(8'h08, 32'h1, rr, hb);
        check("c4_busy_commit_bresp", rr, OKAY);
        released = 0;
        for (int i = 0; i < 40 && !released; i++) begin
            if (hold == 1'b0) released = 1;
            else @(negedge clk);
        end
        check("c4_released", released, 1);
        check("c4_hold_cycles", hold_cnt - base, 17);
        check("c4_window_kept", window_addr, 64'h2_2000_0000);
        read_expect("c4_ctrl_tmo", 8'h08, 32'h4);
        axi_write(8'h08, 32'h4, rr, hb);
        read_expect("c4_ctrl_clr", 8'h08, 32'h0);
        pulse(0, 0, 0, 1);
        read_expect("c4_outst_clr", 8'h14, 32'h0);

        // Underflow sets ERR; commit and clear in one CTRL write both act.
        pulse(0, 1, 0, 0);
        read_expect("c5_ctrl_err", 8'h08, 32'h2);
        read_expect("c5_outst", 8'h14, 32'h0);
        axi_read(8'h20, rd, rr);
        check("c5_unmapped_rresp", rr, SLVERR);
        check("c5_unmapped_rdata", rd, 32'h0);
        axi_write(8'h0C, 32'hFFFF_FFFF, rr, hb);
        check("c5_ro_bresp", rr, SLVERR);
        axi_write(8'h08, 32'h3, rr, hb);
        repeat (3) @(negedge clk);
        read_expect("c5_ctrl_after", 8'h08, 32'h0);
        check("c5_window", window_addr, 64'h2_3000_0000);

        // Reset in the middle of a drain.
        pulse(1, 0, 0, 0);
        axi_write(8'h08, 32'h1, rr, hb);
        @(negedge clk);
        check("c6_hold_before", hold, 1);
        reset = 1;
        @(negedge clk);
        check("c6_hold", hold, 0);
        check("c6_window", window_addr, DEF);
        check("c6_state", dbg_state, 0);
        reset = 0;
        @(negedge clk);
        read_expect("c6_outst", 8'h14, 32'h0);
        read_expect("c6_ctrl", 8'h08, 32'h0);
        read_expect("c6_stage_lo", 8'h00, 32'h0000_1000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
